// File: rtl/gmp_round_ctrl.sv
// Mental-math round sequencer: show LFSR operands, sum mod 100, then judge the player's answer.
// Latency: registered outputs, each display value appears on the edge that enters its state; the verdict comes one cycle after submit.
// Flow: no backpressure. Optional GMP_TIMEOUT_EN bounds the answer window to TIMEOUT_CYCLES.
module gmp_round_ctrl #(
    parameter int NUM_OPERANDS   = 5,
    parameter int SHOW_CYCLES    = 10,
    parameter int GAP_CYCLES     = 2,
    parameter int NUM_ROUNDS     = 7,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       submit,
    input  logic [7:0] answer,
    input  logic [4:0] rnd_in,
    output logic [7:0] display,
    output logic [2:0] op_idx,
    output logic       busy,
    output logic       correct,
    output logic       wrong,
    output logic [3:0] score,
    output logic [3:0] round,
    output logic [6:0] led,
    output logic       game_over
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHOW,
        S_GAP,
        S_WAIT,
        S_CHECK,
        S_RESULT,
        S_DONE
    } state_t;

    localparam int              CW         = $clog2(SHOW_CYCLES + GAP_CYCLES + 1);
    localparam logic [CW-1:0]   SHOW_LAST  = CW'(SHOW_CYCLES - 1);
    localparam logic [CW-1:0]   GAP_LAST   = CW'(GAP_CYCLES - 1);
    localparam logic [2:0]      OP_LAST    = 3'(NUM_OPERANDS - 1);
    localparam logic [3:0]      ROUND_LAST = 4'(NUM_ROUNDS);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [4:0]      operand;
    logic [6:0]      acc;
    logic            start_q;
    logic            submit_q;
    logic            tmo_flag;

    logic            start_edge;
    logic            submit_edge;
    logic            tmo_hit;
    logic [7:0]      acc_sum;
    logic [6:0]      acc_add;
    logic            match;
    logic [3:0]      score_inc;
    logic [6:0]      bar;

    assign start_edge  = start & ~start_q;
    assign submit_edge = submit & ~submit_q;

    // acc <= 99 and rnd_in <= 31, so one conditional subtract keeps the sum mod 100
    assign acc_sum   = {1'b0, acc} + {3'b0, rnd_in};
    assign acc_add   = (acc_sum >= 8'd100) ? 7'(acc_sum - 8'd100) : acc_sum[6:0];
    assign match     = ~tmo_flag && (answer == {1'b0, acc});
    assign score_inc = (score == 4'hF) ? score : score + 4'd1;
    assign bar       = ~(7'h7F >> score);

`ifdef GMP_TIMEOUT_EN
    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_cnt;

    // Cleared whenever we are outside WAIT, so every entry starts a fresh window
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt <= '0;
        end else if (state != S_WAIT) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    assign tmo_hit = (state == S_WAIT) && (tmo_cnt == TMO_LAST);
`else
    // Never fires: the answer window is unbounded in this build
    assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            operand   <= '0;
            acc       <= '0;
            start_q   <= 1'b0;
            submit_q  <= 1'b0;
            tmo_flag  <= 1'b0;
            display   <= '0;
            op_idx    <= '0;
            busy      <= 1'b0;
            correct   <= 1'b0;
            wrong     <= 1'b0;
            score     <= '0;
            round     <= '0;
            led       <= '0;
            game_over <= 1'b0;
        end else begin
            start_q  <= start;
            submit_q <= submit;
            correct  <= 1'b0;
            wrong    <= 1'b0;

            if (abort && state != S_IDLE) begin
                state     <= S_IDLE;
                cnt       <= '0;
                operand   <= '0;
                acc       <= '0;
                tmo_flag  <= 1'b0;
                display   <= '0;
                op_idx    <= '0;
                busy      <= 1'b0;
                score     <= '0;
                round     <= '0;
                led       <= '0;
                game_over <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (start_edge) begin
                            state     <= S_SHOW;
                            cnt       <= '0;
                            score     <= '0;
                            round     <= '0;
                            op_idx    <= '0;
                            operand   <= rnd_in;
                            acc       <= {2'b0, rnd_in};
                            display   <= {3'b0, rnd_in};
                            led       <= '0;
                            busy      <= 1'b1;
                            game_over <= 1'b0;
                        end
                    end

                    S_SHOW: begin
                        led     <= bar;
                        display <= {3'b0, operand};
                        if (cnt == SHOW_LAST) begin
                            state   <= S_GAP;
                            cnt     <= '0;
                            display <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end

                    S_GAP: begin
                        led <= bar;
                        if (cnt == GAP_LAST) begin
                            cnt <= '0;
                            if (op_idx == OP_LAST) begin
                                state   <= S_WAIT;
                                display <= answer;
                            end else begin
                                state   <= S_SHOW;
                                op_idx  <= op_idx + 3'd1;
                                operand <= rnd_in;
                                acc     <= acc_add;
                                display <= {3'b0, rnd_in};
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end

                    S_WAIT: begin
                        led     <= bar;
                        display <= answer;
                        // A submit edge on the timeout cycle still gets a real verdict
                        if (submit_edge) begin
                            state    <= S_CHECK;
                            tmo_flag <= 1'b0;
                        end else if (tmo_hit) begin
                            state    <= S_CHECK;
                            tmo_flag <= 1'b1;
                        end
                    end

                    S_CHECK: begin
                        correct <= match;
                        wrong   <= ~match;
                        if (match) begin
                            score <= score_inc;
                        end
                        state   <= S_RESULT;
                        cnt     <= '0;
                        display <= {1'b0, acc};
                        led     <= match ? 7'h7F : 7'h00;
                    end

                    S_RESULT: begin
                        if (cnt == SHOW_LAST) begin
                            cnt   <= '0;
                            round <= round + 4'd1;
                            if (round + 4'd1 == ROUND_LAST) begin
                                state     <= S_DONE;
                                busy      <= 1'b0;
                                game_over <= 1'b1;
                                display   <= {4'b0, score};
                                led       <= {3'b0, score};
                            end else begin
                                // Next round starts immediately with a fresh accumulator
                                state   <= S_SHOW;
                                op_idx  <= '0;
                                operand <= rnd_in;
                                acc     <= {2'b0, rnd_in};
                                display <= {3'b0, rnd_in};
                                led     <= bar;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end

                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/gmp_round_ctrl.md
Name: gmp_round_ctrl

Overview:
Round sequencer for the mental-math game datapath. Draws NUM_OPERANDS values from the 5-bit LFSR and shows each for a fixed dwell time, separated by blanking gaps. It keeps a running sum mod 100, waits for the player's switch answer and a submit press, then scores the answer. It replaces the free-running slow-clock case decode with an explicit FSM and drives the BCD display value and the LED status.

Parameters:
NUM_OPERANDS, 5, operands per round (2..7)
SHOW_CYCLES, 10, clk cycles each operand and each result is displayed (>=1)
GAP_CYCLES, 2, blank cycles after each operand (>=1)
NUM_ROUNDS, 7, rounds per game (1..15)
TIMEOUT_CYCLES, 1000, answer window in cycles (used only with GMP_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  level; rising edge starts or restarts a game
abort  in  1  synchronous; when 1, forces IDLE next edge
submit  in  1  level; rising edge submits the answer
answer  in  8  player answer (switch[7:0]), binary
rnd_in  in  5  LFSR output
display  out  8  value for binary_to_bcd
op_idx  out  3  index of operand currently shown
busy  out  1  1 in any state except IDLE/DONE
correct  out  1  1-cycle pulse on a correct answer
wrong  out  1  1-cycle pulse on a wrong or timed-out answer
score  out  4  correct answers this game, saturating at 15
round  out  4  completed rounds this game
led  out  7  status LEDs
game_over  out  1  1 in DONE

Behaviour:
- Reset (rst=0): state IDLE; display, op_idx, score, round, accumulator, all counters = 0; correct/wrong/game_over = 0; led = 0; edge-detect registers = 0.
- Edge detect: start_q and submit_q are registered every cycle in every state. A level held across a state change does not generate an edge.
- States: IDLE, SHOW, GAP, WAIT_ANS, CHECK, RESULT, DONE.
- IDLE: display = 0, led = 0. On a start edge: clear score, round and acc; op_idx = 0; go to SHOW.
- Every entry into SHOW latches rnd_in into the operand register and updates acc <= acc + rnd_in, minus 100 if the result is >= 100 (the intermediate value is at most 130, 8 bits).
  - The first SHOW of each round loads acc = rnd_in; acc is not carried over from the previous round.
- SHOW: display = {3'b0, operand}. Lasts exactly SHOW_CYCLES cycles, then GAP.
- GAP: display = 0. Lasts exactly GAP_CYCLES cycles.
  - If op_idx == NUM_OPERANDS-1, go to WAIT_ANS.
  - Otherwise op_idx++ and go to SHOW.
- WAIT_ANS: display = answer, passed live. A submit edge moves to CHECK. Submit edges in any other state are ignored.
- CHECK: one cycle.
  - If answer == acc: correct = 1 and score++ (saturating at 15).
  - Otherwise: wrong = 1.
  - Then go to RESULT.
- RESULT: display = acc for SHOW_CYCLES cycles. led = 7'h7F if the answer was correct, else 7'h00.
  - On exit, round++.
  - If the new round == NUM_ROUNDS, go to DONE.
  - Otherwise go to SHOW with op_idx = 0 (the new round starts immediately).
- DONE: game_over = 1, display = {4'b0, score}, led = {3'b0, score}. A start edge restarts exactly as from IDLE.
- LED outside RESULT/DONE/IDLE: led = ~(7'h7F >> score), i.e. a bar graph.
- start edges while busy are ignored.
- abort = 1 outranks every other input. The next state is IDLE with the same clearing as reset (the rst port itself is not involved). abort has no effect if already in IDLE.
- rst deasserted mid-game: the game is not resumed.
- Outputs are registered; display changes on the edge that enters a state.

Optional Feature:
GMP_TIMEOUT_EN
- Defined: a counter runs in WAIT_ANS. If TIMEOUT_CYCLES elapse with no submit edge, go to CHECK and treat the answer as wrong (wrong pulse, no score change).
  - A submit edge on the same cycle as the timeout wins and is judged normally.
  - The counter clears on every entry into WAIT_ANS.
- Undefined: WAIT_ANS waits indefinitely; no counter logic is synthesized.

Test Plan:
- SHOW_CYCLES=4, GAP_CYCLES=1, rnd_in held at 31, start edge -> five SHOW windows of 4 cycles displaying 31, each followed by 1 cycle of 0; then WAIT_ANS; acc = 55 (155 mod 100).
- Same setup, answer=55, submit edge -> correct pulse 1 cycle, score=1, RESULT display=55 for 4 cycles, led=7'h7F, round=1.
- answer=54, submit edge -> wrong pulse, score unchanged, led=7'h00 during RESULT, display=55.
- NUM_ROUNDS=2, two correct rounds -> DONE, game_over=1, display=2, led=7'h02; start edge -> score=0, SHOW.
- Submit held high from before WAIT_ANS -> no CHECK until submit falls and rises again; abort asserted mid-GAP -> IDLE next cycle, score=0; rst=0 mid-SHOW -> all outputs 0 immediately.
- GMP_TIMEOUT_EN, TIMEOUT_CYCLES=8, no submit -> CHECK after 8 WAIT_ANS cycles, wrong pulse; a submit edge coinciding with the timeout cycle -> judged normally.
